rf_write_arbiter: RTL and testbench

Round-robin arbiter for the single write port (write enable, write address, write data) of the 32×32 MIPS register file. It lets several writeback sources, such as the ALU, load unit and multiply/divide unit, share that port. It accepts at most one write per cycle through a valid/ready handshake and registers the winning write before driving the port. It also suppresses writes to `$0`, which the register file itself does not protect.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rr_grant.sv | 34 +++
 rtl/rf_write_arbiter.sv | 105 ++++++++++
 tb/tb_rf_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the write record used by writeback sources.
// Pure definitions; no logic.
package rf_pkg;
   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_ZERO_IDX = 0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_t;
endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first valid request at or after i_ptr, modulo NREQ.
// Zero latency; i_hold suppresses every grant.
module rr_grant #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [1:0]      i_ptr,
   input  logic            i_hold,
   output logic [NREQ-1:0] o_grant
);
   logic [3:0] w_req4;
   logic [3:0] w_grant4;
   logic [2:0] w_idx;
   logic       w_found;

   // Pad to four lanes so the 2-bit search index always selects a real bit.
   assign w_req4 = 4'(i_req);

   always_comb begin
      w_grant4 = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = {1'b0, i_ptr} + 3'(k);
         if (w_idx >= 3'(NREQ)) w_idx = w_idx - 3'(NREQ);
         if (!i_hold && !w_found && w_req4[w_idx[1:0]]) begin
            w_grant4[w_idx[1:0]] = 1'b1;
            w_found              = 1'b1;
         end
      end
   end

   assign o_grant = w_grant4[NREQ-1:0];
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; one registered write per cycle,
// port driven the cycle after the handshake, $0 writes swallowed. RF_WARB_STATS_EN adds contention_cnt.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hold,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic                   rf_we,
   output logic [ADDR_W-1:0]      rf_addr,
   output logic [DATA_W-1:0]      rf_wdata,
   output logic [1:0]             rf_wsrc
`ifdef RF_WARB_STATS_EN
   ,
   output logic [15:0]            contention_cnt
`endif
);
   logic [1:0]        r_ptr;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_src;

   logic [NREQ-1:0]   w_grant;
   logic              w_xfer;
   logic [1:0]        w_src;
   logic [1:0]        w_next_ptr;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   // Reset gates the grant directly so req_ready drops without a clock edge.
   rr_grant #(.NREQ(NREQ)) u_rr_grant (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_hold  (hold | ~rst_n),
      .o_grant (w_grant)
   );

   assign req_ready = w_grant;

   always_comb begin
      w_xfer = 1'b0;
      w_src  = '0;
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_xfer = 1'b1;
            w_src  = 2'(i);
            w_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_next_ptr = (w_src == 2'(NREQ-1)) ? 2'd0 : w_src + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_src  <= '0;
      end else begin
         r_we <= w_xfer && (w_addr != ADDR_W'(RF_ZERO_IDX));
         if (w_xfer) begin
            r_ptr  <= w_next_ptr;
            r_addr <= w_addr;
            r_data <= w_data;
            r_src  <= w_src;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_addr  = r_addr;
   assign rf_wdata = r_data;
   assign rf_wsrc  = r_src;

`ifdef RF_WARB_STATS_EN
   logic [15:0] r_cnt;
   logic        w_contend;

   assign w_contend = !hold && ($countones(req_valid) > 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_contend && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign contention_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-free reference model.
// A behavioural register file is attached to the write port so end-to-end contents can be compared.
module tb_rf_write_arbiter;
   localparam int NREQ = 2;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 hold;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic                 rf_we;
   logic [AW-1:0]        rf_addr;
   logic [DW-1:0]        rf_wdata;
   logic [1:0]           rf_wsrc;
`ifdef RF_WARB_STATS_EN
   logic [15:0]          contention_cnt;
`endif

   always #5 clk = ~clk;

   rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .rf_wsrc   (rf_wsrc)
`ifdef RF_WARB_STATS_EN
      ,
      .contention_cnt (contention_cnt)
`endif
   );

   // Register file fed by the arbiter's write port.
   logic [31:0] rf_mem [32] = '{default: 32'h0};
   always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

   int checks = 0;
   int errors = 0;

   // Reference model: pointer, one-deep output stage, and expected register contents.
   int          m_ptr  = 0;
   logic        m_we   = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   logic [1:0]  m_src  = '0;
   logic [31:0] exp_mem [32] = '{default: 32'h0};

   function automatic int pick();
      int j;
      if (hold || !rst_n) return -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (m_ptr + k) % NREQ;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      int g;
      g = pick();
      if (g < 0) return '0;
      return NREQ'(1) << g;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = '0;
   endtask

   task automatic tick();
      int g;
      g = pick();
      @(posedge clk);
      if (m_we) exp_mem[m_addr] = m_data;
      if (g >= 0) begin
         m_ptr  = (g + 1) % NREQ;
         m_addr = req_addr[g*AW +: AW];
         m_data = req_data[g*DW +: DW];
         m_src  = 2'(g);
         m_we   = (m_addr != 5'd0);
      end else begin
         m_we = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; hold = 1'b0; req_valid = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hold = 1'b0; req_valid = '1;
      set_req(0, 5'd3, 32'h1234_5678); set_req(1, 5'd4, 32'h8765_4321);
      model_reset();
      #2;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
      checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", rf_addr); end
      checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
      checks++; if (rf_wsrc !== 2'd0) begin errors++; $display("FAIL reset_wsrc: got %0d want 0", rf_wsrc); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
      @(negedge clk);
      checks++; if (req_ready !== 2'b00 || rf_we !== 1'b0) begin errors++; $display("FAIL reset_edge: ready %b we %b want 00 0", req_ready, rf_we); end
      req_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      set_req(0, 5'd5, 32'hDEAD_BEEF);
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", rf_we); end
      checks++; if (rf_addr !== 5'd5) begin errors++; $display("FAIL single_addr: got %0d want 5", rf_addr); end
      checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
      checks++; if (rf_wsrc !== 2'd0) begin errors++; $display("FAIL single_wsrc: got %0d want 0", rf_wsrc); end
      tick();
      checks++; if (rf_mem[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf5: got %h want deadbeef", rf_mem[5]); end
      checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd5) begin errors++; $display("FAIL single_idle: we %b addr %0d want 0 5", rf_we, rf_addr); end
   endtask

   task automatic test_fairness();
      int g;
      logic [NREQ-1:0] want;
      do_reset();
      set_req(0, 5'd10, $urandom); set_req(1, 5'd20, $urandom);
      req_valid = 2'b11;
      for (int c = 0; c < 6; c++) begin
         #1;
         want = 2'b01 << (c % 2);
         checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, want); end
         if (c > 0) begin
            checks++; if (rf_we !== 1'b1 || rf_wsrc !== m_src) begin errors++; $display("FAIL fair_out%0d: we %b src %0d want 1 %0d", c, rf_we, rf_wsrc, m_src); end
         end
         g = pick();
         tick();
         if (g >= 0) set_req(g, 5'(10 + c), $urandom);
      end
      req_valid = '0;
      checks++; if (rf_we !== 1'b1 || rf_wsrc !== 2'd1) begin errors++; $display("FAIL fair_last: we %b src %0d want 1 1", rf_we, rf_wsrc); end
      tick();
   endtask

   task automatic test_zero();
      do_reset();
      set_req(1, 5'd0, 32'hFFFF_FFFF);
      req_valid = 2'b10;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b want 10", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", rf_we); end
      checks++; if (rf_wsrc !== 2'd1) begin errors++; $display("FAIL zero_wsrc: got %0d want 1", rf_wsrc); end
      set_req(0, 5'd3, 32'h3333_3333); set_req(1, 5'd4, 32'h4444_4444);
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL zero_ptr: got %b want 01", req_ready); end
      tick();
      req_valid = '0;
      tick();
      checks++; if (rf_mem[0] !== 32'd0) begin errors++; $display("FAIL zero_rf0: got %h want 0", rf_mem[0]); end
   endtask

   task automatic test_hold();
      do_reset();
      set_req(0, 5'd9, 32'h9999_0000);
      req_valid = 2'b01;
      tick();
      set_req(0, 5'd11, 32'hAAAA_0001); set_req(1, 5'd12, 32'hBBBB_0002);
      req_valid = 2'b11;
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready%0d: got %b want 00", c, req_ready); end
         tick();
         checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_we%0d: got %b want 0", c, rf_we); end
      end
      checks++; if (rf_mem[9] !== 32'h9999_0000) begin errors++; $display("FAIL hold_inflight: got %h want 99990000", rf_mem[9]); end
      hold = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_release: got %b want 10", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (rf_wsrc !== 2'd1 || rf_addr !== 5'd12) begin errors++; $display("FAIL hold_out: src %0d addr %0d want 1 12", rf_wsrc, rf_addr); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 5'd7, 32'h1111_1111);
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      tick();
      tick();
      set_req(0, 5'd7, 32'h2222_2222);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b11;
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", rf_we); end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b want 0", rf_we); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_ready: got %b want 00", req_ready); end
      tick();
      tick();
      checks++; if (rf_mem[7] !== 32'h1111_1111) begin errors++; $display("FAIL rmid_rf7: got %h want 11111111", rf_mem[7]); end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_ptr: got %b want 01", req_ready); end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               set_req(i, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
         end
         hold = ($urandom_range(0, 7) == 0);
         #1;
         checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", c, req_ready, exp_ready()); end
         g = pick();
         tick();
         if (g >= 0) req_valid[g] = 1'b0;
         checks++; if (rf_we !== m_we || rf_addr !== m_addr || rf_wdata !== m_data || rf_wsrc !== m_src) begin
            errors++; $display("FAIL rnd_out%0d: got we %b a %0d d %h s %0d want %b %0d %h %0d", c, rf_we, rf_addr, rf_wdata, rf_wsrc, m_we, m_addr, m_data, m_src);
         end
      end
      hold = 1'b0; req_valid = '0;
      tick();
      tick();
      for (int i = 0; i < 32; i++) begin
         checks++; if (rf_mem[i] !== exp_mem[i]) begin errors++; $display("FAIL rnd_rf%0d: got %h want %h", i, rf_mem[i], exp_mem[i]); end
      end
   endtask

`ifdef RF_WARB_STATS_EN
   task automatic test_stats();
      int g;
      do_reset();
      checks++; if (contention_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d want 0", contention_cnt); end
      set_req(0, 5'd1, $urandom); set_req(1, 5'd2, $urandom);
      req_valid = 2'b11;
      for (int c = 0; c < 10; c++) begin
         g = pick();
         tick();
         if (g >= 0) set_req(g, 5'(c + 1), $urandom);
      end
      hold = 1'b1;
      tick();
      tick();
      checks++; if (contention_cnt !== 16'd10) begin errors++; $display("FAIL stats_cnt: got %0d want 10", contention_cnt); end
      hold = 1'b0; req_valid = '0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_zero();
      test_hold();
      test_reset_mid();
      test_random();
`ifdef RF_WARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
